// File: rtl/mul_div_if.sv
// Operand/funct/handshake bundle between the EX stage and mul_div_unit.
//   dataA, dataB : 32-bit operands (multiplicand/dividend, multiplier/divisor)
//   Signal       : 6-bit R-type funct code
//   start        : operation request
//   busy, done   : status from the unit
//   dataOut      : HI/LO read-back
interface mul_div_if;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] dataOut;

  modport master (output dataA, dataB, Signal, start,
                  input  busy, done, dataOut);
  modport slave  (input  dataA, dataB, Signal, start,
                  output busy, done, dataOut);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative unsigned MULTU/DIVU unit with HI/LO result registers.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : mul_div_if slave (operands, funct, start/busy/done, dataOut)
// One multiplier/quotient bit per cycle over 32 RUN cycles, then one DONE cycle.
module mul_div_unit (
  input  logic       clk,
  input  logic       reset,
  mul_div_if.slave   bus
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 6;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [2*W-1:0]   a_q, a_d;     // multiplicand (shifts left) / dividend bits (MSB out)
  logic [W-1:0]     b_q, b_d;     // multiplier (shifts right) / divisor
  logic [2*W-1:0]   acc_q, acc_d; // product, or {remainder, quotient}
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;

  logic             accept;
  logic [W:0]       shifted;      // partial remainder with next dividend bit appended
  logic [W+1:0]     diff;         // extra MSB is the borrow of the trial subtract
  logic             qbit;
  logic [W-1:0]     rem;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next-state, iteration step and result write-back
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    accept  = bus.start && (state_q != RUN) &&
              ((bus.Signal == FN_MULTU) || (bus.Signal == FN_DIVU));
    shifted = {acc_q[2*W-1:W], a_q[W-1]};
    diff    = {1'b0, shifted} - {2'b00, b_q};
    qbit    = 1'b0;
    rem     = shifted[W-1:0];

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d  = RUN;
          cnt_d    = '0;
          is_div_d = (bus.Signal == FN_DIVU);
          a_d      = {{W{1'b0}}, bus.dataA};
          b_d      = bus.dataB;
          acc_d    = '0;
        end
      end
      RUN: begin
        if (is_div_q) begin
          // Restoring step: keep the difference only when no borrow occurred
          qbit  = ~diff[W+1];
          rem   = qbit ? W'(diff) : shifted[W-1:0];
          acc_d = {rem, acc_q[W-2:0], qbit};
          a_d   = a_q << 1;
        end else begin
          if (b_q[0]) begin
            acc_d = acc_q + a_q;
          end
          a_d = a_q << 1;
          b_d = b_q >> 1;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          hi_d    = acc_d[2*W-1:W];
          lo_d    = acc_d[W-1:0];
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);

  // Read-back straight from HI/LO; in-flight results are not visible
  always_comb begin
    case (bus.Signal)
      FN_MFHI: bus.dataOut = hi_q;
      FN_MFLO: bus.dataOut = lo_q;
      default: bus.dataOut = '0;
    endcase
  end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_ADD   = 6'b100001;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mul_div_if bus ();

  mul_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result {HI, LO} computed from the arithmetic definition
  function automatic logic [63:0] model(input logic is_div, input logic [31:0] a,
                                        input logic [31:0] b);
    if (!is_div) return 64'(a) * 64'(b);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  // Drive a request at the current negedge; returns one cycle after acceptance edge
  task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    bus.Signal = fn;
    bus.dataA  = a;
    bus.dataB  = b;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.Signal = FN_ADD;
    bus.dataA  = $urandom;
    bus.dataB  = $urandom;
  endtask

  // Step cycles until done, bounded; lat counts cycles since the acceptance edge
  task automatic wait_done(input int lat0, output int lat, output int busyc);
    lat   = lat0;
    busyc = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    bus.Signal = FN_MFHI;
    #1 hi = bus.dataOut;
    bus.Signal = FN_MFLO;
    #1 lo = bus.dataOut;
    bus.Signal = FN_ADD;
  endtask

  task automatic test_reset;
    logic [31:0] hi, lo;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    read_hilo(hi, lo);
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'd0); end
    checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'd0); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
  endtask

  task automatic test_mul_full;
    int lat, busyc;
    logic [31:0] hi, lo;
    logic [63:0] exp;
    exp = model(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, lat, busyc);
    checks++; if (lat !== 33) begin failures++; $display("FAIL mul_latency got=%0d exp=33", lat); end
    checks++; if (busyc !== 32) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=32", busyc); end
    read_hilo(hi, lo);
    checks++; if (hi !== 32'hFFFF_FFFE || hi !== exp[63:32])
      begin failures++; $display("FAIL mul_full_hi got=%h exp=%h", hi, 32'hFFFF_FFFE); end
    checks++; if (lo !== 32'h0000_0001 || lo !== exp[31:0])
      begin failures++; $display("FAIL mul_full_lo got=%h exp=%h", lo, 32'h0000_0001); end
    bus.Signal = FN_MULTU;
    #1;
    checks++; if (bus.dataOut !== 32'd0) begin failures++; $display("FAIL other_fn_dataout got=%h exp=0", bus.dataOut); end
    bus.Signal = FN_ADD;
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mul_done_width got=%b exp=0", bus.done); end
  endtask

  task automatic test_div_overlap;
    int lat, busyc;
    logic [31:0] hi, lo;
    issue(FN_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    bus.Signal = FN_MULTU;
    bus.dataA  = 32'd3;
    bus.dataB  = 32'd5;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.Signal = FN_ADD;
    wait_done(11, lat, busyc);
    checks++; if (lat !== 33) begin failures++; $display("FAIL div_overlap_latency got=%0d exp=33", lat); end
    read_hilo(hi, lo);
    checks++; if (lo !== 32'd14) begin failures++; $display("FAIL div_overlap_lo got=%0d exp=14", lo); end
    checks++; if (hi !== 32'd2) begin failures++; $display("FAIL div_overlap_hi got=%0d exp=2", hi); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL div_overlap_requeued got=%b exp=0", bus.busy); end
  endtask

  task automatic test_div_zero;
    int lat, busyc;
    logic [31:0] hi, lo;
    issue(FN_DIVU, 32'h0000_1234, 32'd0);
    wait_done(1, lat, busyc);
    checks++; if (lat !== 33) begin failures++; $display("FAIL divz_latency got=%0d exp=33", lat); end
    read_hilo(hi, lo);
    checks++; if (hi !== 32'h0000_1234) begin failures++; $display("FAIL divz_hi got=%h exp=%h", hi, 32'h0000_1234); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divz_lo got=%h exp=%h", lo, 32'hFFFF_FFFF); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat, busyc, seen;
    logic [31:0] hi, lo;
    issue(FN_MULTU, 32'd6, 32'd7);
    wait_done(1, lat, busyc);
    read_hilo(hi, lo);
    checks++; if (lo !== 32'd42) begin failures++; $display("FAIL rmid_pre_lo got=%0d exp=42", lo); end
    @(negedge clk);
    issue(FN_DIVU, 32'd50, 32'd5);
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
    seen = 0;
    repeat (40) begin
      if (bus.done) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rmid_done_pulses got=%0d exp=0", seen); end
    read_hilo(hi, lo);
    checks++; if (lo !== 32'd0) begin failures++; $display("FAIL rmid_lo got=%h exp=0", lo); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL rmid_hi got=%h exp=0", hi); end
  endtask

  task automatic test_back_to_back;
    int lat, busyc;
    logic [31:0] hi, lo;
    issue(FN_MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_done(1, lat, busyc);
    checks++; if (busyc !== 32) begin failures++; $display("FAIL b2b_first_busy got=%0d exp=32", busyc); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_done_busy got=%b exp=0", bus.busy); end
    read_hilo(hi, lo);
    checks++; if (hi !== 32'd1) begin failures++; $display("FAIL b2b_first_hi got=%h exp=1", hi); end
    checks++; if (lo !== 32'd0) begin failures++; $display("FAIL b2b_first_lo got=%h exp=0", lo); end
    issue(FN_DIVU, 32'd9, 32'd2);
    wait_done(1, lat, busyc);
    checks++; if (lat !== 33) begin failures++; $display("FAIL b2b_interval got=%0d exp=33", lat); end
    checks++; if (busyc !== 32) begin failures++; $display("FAIL b2b_second_busy got=%0d exp=32", busyc); end
    read_hilo(hi, lo);
    checks++; if (lo !== 32'd4) begin failures++; $display("FAIL b2b_second_lo got=%0d exp=4", lo); end
    checks++; if (hi !== 32'd1) begin failures++; $display("FAIL b2b_second_hi got=%0d exp=1", hi); end
    @(negedge clk);
  endtask

  task automatic test_random;
    int lat, busyc;
    logic [31:0] a, b, hi, lo;
    logic        is_div;
    logic [63:0] exp;
    for (int i = 0; i < 10; i++) begin
      is_div = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) b = b >> $urandom_range(0, 31);
      if (i == 7) b = 32'd0;
      exp = model(is_div, a, b);
      issue(is_div ? FN_DIVU : FN_MULTU, a, b);
      wait_done(1, lat, busyc);
      checks++; if (lat !== 33) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=33", i, lat); end
      read_hilo(hi, lo);
      checks++; if ({hi, lo} !== exp)
        begin failures++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h exp=%h", i, is_div, a, b, {hi, lo}, exp); end
      @(negedge clk);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.Signal = FN_ADD;
    bus.dataA  = '0;
    bus.dataB  = '0;
    @(negedge clk);
    test_reset;
    test_mul_full;
    test_div_overlap;
    test_div_zero;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle unsigned multiply/divide unit that sits beside the 32-bit combinational ALU in the EX stage of the pipelined datapath. It takes the same operand buses and the same 6-bit R-type funct code as the ALU. It runs MULTU/DIVU iteratively into internal HI/LO registers and returns them on MFHI/MFLO. A start/busy/done handshake lets the hazard unit stall the pipeline while an operation is in flight.

## Interface
- No parameters; data width fixed at 32.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears all state
- dataA  input  32  operand A (multiplicand / dividend)
- dataB  input  32  operand B (multiplier / divisor)
- Signal  input  6  funct code: MULTU 6'b011001, DIVU 6'b011011, MFHI 6'b010000, MFLO 6'b010010
- start  input  1  request; sampled only together with a MULTU or DIVU Signal
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse; HI/LO valid
- dataOut  output  32  HI on MFHI, LO on MFLO, else 0 (combinational from HI/LO)

## Operation
- States: IDLE, RUN, DONE. 6-bit iteration counter cnt.
- Accept condition: start=1, busy=0, Signal is MULTU or DIVU.
  - Accepted at edge E0: latch dataA, dataB and the op; cnt=0; go to RUN.
  - Accept is allowed in IDLE or DONE.
  - start with any other Signal is ignored.
  - start while busy=1 is ignored; no queueing.
- MULTU: shift-add, one multiplier bit per cycle, LSB first.
  - 64-bit accumulator; product = {HI,LO}, full 64-bit unsigned result.
- DIVU: restoring division, one quotient bit per cycle, MSB first.
  - 33-bit partial-remainder subtract.
  - LO = quotient, HI = remainder.
  - Divide by zero is not special-cased and yields LO=32'hFFFFFFFF, HI=dataA.
- RUN performs exactly 32 iterations, cnt 0..31.
  - When cnt=31: write HI/LO and go to DONE.
- DONE lasts one cycle; returns to IDLE unless a new request is accepted in the same cycle.
- HI/LO change only on completion. Aborted operations never modify HI/LO.
- dataOut:
  - Reads the HI/LO registers, so during RUN MFHI/MFLO return the previous result.
  - Stalling around reads is the hazard unit's job.
  - Any Signal other than MFHI/MFLO gives dataOut = 0.
- Reset, at any time including mid-RUN:
  - Next edge: state=IDLE, cnt=0, HI=LO=0, operand latches=0.
  - The in-flight operation is discarded.

## Timing
- Reset values: busy=0, done=0, dataOut=0 (HI=LO=0).
- busy = (state==RUN). It is high for exactly 32 cycles, starting the cycle after E0.
- done = (state==DONE). It is high for exactly 1 cycle, the cycle after edge E32.
- HI/LO are visible from the cycle after E32, concurrent with done.
- Latency: accepted start to done = 33 cycles.
- Back-to-back: a start accepted in the DONE cycle begins RUN at the next edge. Issue interval is therefore 33 cycles.
- Simultaneous reset and start: reset wins; no operation is accepted.
- Operands may change after E0 without affecting the result.

## Test plan
- Reset then idle.
  - Stimulus: reset=1 for 2 cycles; then Signal=MFHI, then MFLO.
  - Required: dataOut=0 for both reads; busy=0, done=0.
- MULTU full-range product.
  - Stimulus: MULTU with dataA=dataB=32'hFFFFFFFF, start=1 for 1 cycle.
  - Required: busy high for exactly 32 cycles; done high for exactly 1 cycle at cycle 33.
  - Required: MFHI -> 32'hFFFFFFFE; MFLO -> 32'h00000001.
- DIVU plus overlapping start.
  - Stimulus: DIVU with dataA=100, dataB=7.
  - Stimulus: assert start again with MULTU, dataA=3, dataB=5 at cycle 10 of RUN.
  - Required: the second request is ignored.
  - Required: after done, MFLO -> 14, MFHI -> 2.
- Divide by zero.
  - Stimulus: DIVU with dataA=32'h00001234, dataB=0.
  - Required: after done, MFHI -> 32'h00001234, MFLO -> 32'hFFFFFFFF.
- Reset mid-operation.
  - Stimulus: first complete a MULTU 6x7 (LO=42).
  - Stimulus: start DIVU 50/5; assert reset at RUN cycle 16.
  - Required: next cycle busy=0; done never pulses.
  - Required: MFLO -> 0, MFHI -> 0.
- Back-to-back ops.
  - Stimulus: MULTU 32'h00010000 x 32'h00010000; issue DIVU 9/2 in its DONE cycle.
  - Required: the first done cycle shows HI=1, LO=0.
  - Required: the second done arrives exactly 33 cycles later with LO=4, HI=1.
  - Required: busy is low only during the single DONE cycle between the two operations.
